// File: rtl/note_pkg.sv
// Shared note-game definitions used by the judge and the note sequencer.
package note_pkg;

  localparam int unsigned LANES           = 5;
  localparam int unsigned STEP_CYCLES     = 13157896;
  localparam int unsigned POINTS_PER_NOTE = 10;
  localparam int unsigned MULT_T1         = 10;
  localparam int unsigned MULT_T2         = 20;
  localparam int unsigned MULT_T3         = 30;
  localparam int unsigned MULT_W          = 3;

  // One row of the highway: bit i set means a note in fret lane i.
  typedef logic [LANES-1:0] note_t;

  // Score multiplier earned by a given streak length.
  function automatic logic [MULT_W-1:0] mult_of(input int unsigned streak_len);
    logic [MULT_W-1:0] m;
    if (streak_len < MULT_T1) begin
      m = MULT_W'(1);
    end else if (streak_len < MULT_T2) begin
      m = MULT_W'(2);
    end else if (streak_len < MULT_T3) begin
      m = MULT_W'(3);
    end else begin
      m = MULT_W'(4);
    end
    return m;
  endfunction

endpackage

// File: rtl/note_judge_step_timer.sv
// Eighth-note step timer, shared with the note sequencer so both stay in lockstep.
//   clk, resetn : clock, synchronous active-low reset
//   pause       : holds the count and suppresses step_c
//   stop        : forces the count back to zero
//   step_c      : combinational, high during the last cycle of each step
module step_timer #(
  parameter int unsigned STEP_CYCLES = note_pkg::STEP_CYCLES
) (
  input  logic clk,
  input  logic resetn,
  input  logic pause,
  input  logic stop,
  output logic step_c
);
  import note_pkg::*;

  localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Step on the final count; the counter wraps on that same edge.
  always_comb begin
    count_d = count_q;
    step_c  = (count_q == LAST) & ~pause;
    if (stop) begin
      count_d = '0;
    end else if (!pause) begin
      count_d = step_c ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/note_judge.sv
// Note highway and strum judge: scrolls the expected-note pattern down a
// DEPTH-row highway once per step and judges strums against the strike row.
//   clk, resetn      : clock, synchronous active-low reset
//   pause, stop      : freeze / song restart
//   exp_notes        : pattern from the sequencer, loaded into row 0 on each step
//   frets, strum     : debounced player inputs
//   highway          : row r at [r*LANES +: LANES], row DEPTH-1 is the strike row
//   hit/miss_pulse   : one-cycle judgement pulses
//   score, streak, multiplier : HUD values
module note_judge #(
  parameter int unsigned LANES       = note_pkg::LANES,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned STEP_CYCLES = note_pkg::STEP_CYCLES,
  parameter int unsigned SCORE_W     = 16,
  parameter int unsigned STREAK_W    = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   pause,
  input  logic                   stop,
  input  logic [LANES-1:0]       exp_notes,
  input  logic [LANES-1:0]       frets,
  input  logic                   strum,
  output logic [DEPTH*LANES-1:0] highway,
  output logic                   hit_pulse,
  output logic                   miss_pulse,
  output logic [SCORE_W-1:0]     score,
  output logic [STREAK_W-1:0]    streak,
  output logic [2:0]             multiplier
);
  import note_pkg::*;

  localparam int unsigned HW_W  = DEPTH * LANES;
  localparam int unsigned SUM_W = SCORE_W + 1;

  logic step_c;

  step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_step_timer (
    .clk    (clk),
    .resetn (resetn),
    .pause  (pause),
    .stop   (stop),
    .step_c (step_c)
  );

  logic [HW_W-1:0]     highway_q, highway_d;
  logic                judged_q, judged_d;
  logic                strum_in_q, strum_in_d;
  logic                strum_dly_q, strum_dly_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [2:0]          mult_q, mult_d;
  logic                hit_q, hit_d;
  logic                miss_q, miss_d;

  logic [LANES-1:0] strike_c;
  logic             edge_c;
  logic             live_c;
  logic [SUM_W-1:0] score_sum_c;

  // Strum is registered first, so the edge (and the judgement one cycle later)
  // sits a full cycle behind the button sample.
  assign strike_c    = highway_q[(DEPTH-1)*LANES +: LANES];
  assign edge_c      = strum_in_q & ~strum_dly_q & ~pause;
  assign live_c      = (strike_c != '0) & ~judged_q;
  assign score_sum_c = SUM_W'(score_q) + SUM_W'(POINTS_PER_NOTE * 32'(mult_q));

  // Judgement, shift and HUD update.
  always_comb begin
    highway_d   = highway_q;
    judged_d    = judged_q;
    strum_in_d  = strum;
    strum_dly_d = strum_in_q;
    score_d     = score_q;
    streak_d    = streak_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;

    if (stop) begin
      highway_d = '0;
      judged_d  = 1'b0;
      streak_d  = '0;
    end else begin
      if (edge_c) begin
        if (live_c && (frets == strike_c)) begin
          hit_d    = 1'b1;
          judged_d = 1'b1;
          score_d  = score_sum_c[SCORE_W] ? '1 : score_sum_c[SCORE_W-1:0];
          streak_d = (streak_q == '1) ? streak_q : streak_q + STREAK_W'(1);
        end else begin
          // Wrong frets on a live row, or an overstrum on an empty/judged row.
          miss_d   = 1'b1;
          streak_d = '0;
          if (live_c) begin
            judged_d = 1'b1;
          end
        end
      end else if (step_c && live_c) begin
        // Unjudged note scrolls off the strike row.
        miss_d   = 1'b1;
        streak_d = '0;
      end

      if (step_c) begin
        highway_d = {highway_q[HW_W-LANES-1:0], exp_notes};
        judged_d  = 1'b0;
      end
    end

    mult_d = mult_of(32'(streak_d));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      highway_q   <= '0;
      judged_q    <= 1'b0;
      strum_in_q  <= 1'b0;
      strum_dly_q <= 1'b0;
      score_q     <= '0;
      streak_q    <= '0;
      mult_q      <= 3'd1;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      highway_q   <= highway_d;
      judged_q    <= judged_d;
      strum_in_q  <= strum_in_d;
      strum_dly_q <= strum_dly_d;
      score_q     <= score_d;
      streak_q    <= streak_d;
      mult_q      <= mult_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  assign highway    = highway_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
  assign score      = score_q;
  assign streak     = streak_q;
  assign multiplier = mult_q;

endmodule

// File: tb/tb_note_judge.sv
// Directed bench for note_judge with a 4-row highway and 4-cycle steps.
module tb_note_judge;

  localparam int unsigned LANES = 5;
  localparam int unsigned DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic                   pause;
  logic                   stop;
  logic [LANES-1:0]       exp_notes;
  logic [LANES-1:0]       frets;
  logic                   strum;
  logic [DEPTH*LANES-1:0] highway;
  logic                   hit_pulse;
  logic                   miss_pulse;
  logic [15:0]            score;
  logic [7:0]             streak;
  logic [2:0]             multiplier;

  int vectors = 0;
  int errors  = 0;

  note_judge #(
    .LANES(LANES), .DEPTH(DEPTH), .STEP_CYCLES(4), .SCORE_W(16), .STREAK_W(8)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pause      (pause),
    .stop       (stop),
    .exp_notes  (exp_notes),
    .frets      (frets),
    .strum      (strum),
    .highway    (highway),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .score      (score),
    .streak     (streak),
    .multiplier (multiplier)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int exp_score;
  int exp_streak;
  int mult_before;

  initial begin
    resetn = 1'b0; pause = 1'b0; stop = 1'b0;
    exp_notes = '0; frets = '0; strum = 1'b0;

    // Reset
    tick(2);
    check("rst_highway", 32'(highway), 32'h0);
    check("rst_hit", 32'(hit_pulse), 32'h0);
    check("rst_miss", 32'(miss_pulse), 32'h0);
    check("rst_score", 32'(score), 32'h0);
    check("rst_streak", 32'(streak), 32'h0);
    check("rst_mult", 32'(multiplier), 32'h1);
    resetn = 1'b1;
    exp_notes = 5'b00101;

    // Shift: pattern enters row 0 on step edge E4 and reaches row 3 at E16
    tick(4);                                             // E4
    check("shift_row0", 32'(highway), 32'h00005);
    exp_notes = 5'b00000;
    tick(11);                                            // E15
    strum = 1'b1; frets = 5'b00101;
    tick(1);                                             // E16
    check("shift_row3", 32'(highway), 32'h28000);
    check("hit_latency", 32'(hit_pulse), 32'h0);
    tick(1);                                             // E17
    check("hit_pulse", 32'(hit_pulse), 32'h1);
    check("hit_nomiss", 32'(miss_pulse), 32'h0);
    check("hit_score", 32'(score), 32'd10);
    check("hit_streak", 32'(streak), 32'd1);
    strum = 1'b0;
    tick(1);                                             // E18
    check("hit_one_cycle", 32'(hit_pulse), 32'h0);
    strum = 1'b1;
    tick(1);                                             // E19
    check("over_latency", 32'(miss_pulse), 32'h0);
    tick(1);                                             // E20: overstrum on judged row + step
    check("over_miss", 32'(miss_pulse), 32'h1);
    check("over_nohit", 32'(hit_pulse), 32'h0);
    check("over_streak", 32'(streak), 32'd0);
    check("over_score", 32'(score), 32'd10);
    check("over_highway", 32'(highway), 32'h0);
    strum = 1'b0;
    exp_notes = 5'b00101;
    tick(1);                                             // E21
    check("over_one_cycle", 32'(miss_pulse), 32'h0);

    // Queue four patterns
    tick(3); exp_notes = 5'b01010;                       // E24
    tick(4); exp_notes = 5'b10100;                       // E28
    tick(4); exp_notes = 5'b00011;                       // E32
    tick(4); exp_notes = 5'b00000;                       // E36
    check("queue_highway", 32'(highway), 32'h2AA83);
    strum = 1'b1; frets = 5'b00101;
    tick(2);                                             // E38
    check("hit2_pulse", 32'(hit_pulse), 32'h1);
    check("hit2_score", 32'(score), 32'd20);
    check("hit2_streak", 32'(streak), 32'd1);
    strum = 1'b0;
    tick(2);                                             // E40: judged row leaves quietly
    check("judged_noexpire", 32'(miss_pulse), 32'h0);

    // Wrong fret
    frets = 5'b01000; strum = 1'b1;
    tick(2);                                             // E42
    check("wrong_miss", 32'(miss_pulse), 32'h1);
    check("wrong_nohit", 32'(hit_pulse), 32'h0);
    check("wrong_streak", 32'(streak), 32'd0);
    check("wrong_score", 32'(score), 32'd20);
    strum = 1'b0;
    tick(2);                                             // E44
    check("wrong_noexpire", 32'(miss_pulse), 32'h0);

    // Expire: 10100 scrolls off unjudged at E48
    tick(3);                                             // E47
    check("expire_before", 32'(miss_pulse), 32'h0);
    tick(1);                                             // E48
    check("expire_miss", 32'(miss_pulse), 32'h1);
    check("expire_highway", 32'(highway), 32'h18000);
    tick(1);                                             // E49
    check("expire_one_cycle", 32'(miss_pulse), 32'h0);

    // Strum edge on the step cycle: hit only
    tick(1);                                             // E50
    strum = 1'b1; frets = 5'b00011;
    tick(1);                                             // E51
    check("simul_latency", 32'(hit_pulse), 32'h0);
    tick(1);                                             // E52
    check("simul_hit", 32'(hit_pulse), 32'h1);
    check("simul_nomiss", 32'(miss_pulse), 32'h0);
    check("simul_score", 32'(score), 32'd30);
    check("simul_highway", 32'(highway), 32'h0);
    strum = 1'b0;
    tick(1);                                             // E53
    check("simul_after_hit", 32'(hit_pulse), 32'h0);
    check("simul_after_miss", 32'(miss_pulse), 32'h0);

    // Overstrum on an empty strike row
    strum = 1'b1;
    tick(2);                                             // E55
    check("empty_over_miss", 32'(miss_pulse), 32'h1);
    check("empty_over_score", 32'(score), 32'd30);
    check("empty_over_streak", 32'(streak), 32'd0);
    strum = 1'b0; exp_notes = 5'b11111; frets = 5'b11111;

    // Multiplier: eleven consecutive hits, one per step
    tick(13);                                            // E68
    exp_score = 30; exp_streak = 0;
    for (int j = 0; j < 11; j++) begin
      strum = 1'b1;
      tick(2);
      mult_before = (exp_streak < 10) ? 1 : 2;
      exp_score  += 10 * mult_before;
      exp_streak += 1;
      check("mult_hit", 32'(hit_pulse), 32'h1);
      check("mult_score", 32'(score), 32'(exp_score));
      check("mult_streak", 32'(streak), 32'(exp_streak));
      check("mult_value", 32'(multiplier), (exp_streak < 10) ? 32'd1 : 32'd2);
      strum = 1'b0;
      tick(2);
      check("mult_noexpire", 32'(miss_pulse), 32'h0);
    end
    check("mult_final_score", 32'(score), 32'd150);
    check("mult_final_streak", 32'(streak), 32'd11);

    // Pause mid-step: count frozen at 1, strum activity ignored
    tick(1);                                             // E113
    pause = 1'b1; exp_notes = 5'b00000;
    for (int p = 1; p <= 20; p++) begin
      tick(1);
      check("pause_hit", 32'(hit_pulse), 32'h0);
      check("pause_miss", 32'(miss_pulse), 32'h0);
      check("pause_highway", 32'(highway), 32'hFFFFF);
      if (p == 5)  strum = 1'b1;
      if (p == 10) strum = 1'b0;
      if (p == 15) strum = 1'b1;
    end
    check("pause_score", 32'(score), 32'd150);
    pause = 1'b0;
    tick(1);
    check("resume1_hit", 32'(hit_pulse), 32'h0);
    check("resume1_miss", 32'(miss_pulse), 32'h0);
    check("resume1_highway", 32'(highway), 32'hFFFFF);
    tick(1);
    check("resume2_miss", 32'(miss_pulse), 32'h0);
    check("resume2_highway", 32'(highway), 32'hFFFFF);
    tick(1);
    check("resume_expire", 32'(miss_pulse), 32'h1);
    check("resume_shift", 32'(highway), 32'hFFFE0);
    check("resume_streak", 32'(streak), 32'd0);
    check("resume_mult", 32'(multiplier), 32'd1);

    // Stop: clears highway/streak, holds score, restarts timer
    stop = 1'b1; strum = 1'b0;
    tick(1);
    check("stop_highway", 32'(highway), 32'h0);
    check("stop_streak", 32'(streak), 32'd0);
    check("stop_score", 32'(score), 32'd150);
    check("stop_miss", 32'(miss_pulse), 32'h0);
    stop = 1'b0; exp_notes = 5'b00111;
    tick(3);
    check("restart_before", 32'(highway), 32'h0);
    tick(1);
    check("restart_step", 32'(highway), 32'h00007);

    // Reset clears the held score
    resetn = 1'b0;
    tick(1);
    check("rst2_score", 32'(score), 32'h0);
    check("rst2_highway", 32'(highway), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
